sdp_ram_axi: RTL

Simple-dual-port RAM block with a full AXI4 slave front-end. It is the parametrised successor to the write-only AXI RAM interface, and adds:
- byte-enable (WSTRB) writes, transaction IDs and strict AW-before-W ordering;
- WLAST checking, with SLVERR reported on mismatch;
- an optional AXI read path;
- a wrap counter alongside the last-word pulse.

It sits between the host AXI interconnect and datapath logic that reads the RAM through the local `addrb`/`dob` port.

---
 rtl/sdp_ram_axi.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdp_ram_axi.sv
// Simple-dual-port RAM with an AXI4 write slave, optional AXI read slave and a local read port.
// Writes land one cycle after the W handshake; local reads return one cycle after addrb.

module sdp_ram_axi_bank #(
  parameter int    DW = 512,
  parameter int    DD = 16384,
  parameter string RAM_TYPE = "ultra",
  localparam int   AW = $clog2(DD)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  if (RAM_TYPE == "ultra") begin : g_ultra
    (* ram_style = "ultra" *) logic [DW-1:0] mem [DD];
    always_ff @(posedge clk) begin
      for (int b = 0; b < DW/8; b++)
        if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      rdata <= mem[raddr];
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [DW-1:0] mem [DD];
    always_ff @(posedge clk) begin
      for (int b = 0; b < DW/8; b++)
        if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      rdata <= mem[raddr];
    end
  end
endmodule

module sdp_ram_axi #(
  parameter int    DW = 512,
  parameter int    DD = 16384,
  parameter int    IDW = 4,
  parameter int    AXI_READ = 0,
  parameter string RAM_TYPE = "ultra",
  localparam int   AW = $clog2(DD),
  localparam int   BA = $clog2(DD * DW / 8)
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            last_word_written,
  output logic [31:0]     wrap_count,
  input  logic [AW-1:0]   addrb,
  output logic [DW-1:0]   dob,
  input  logic [BA-1:0]   S_AXI_AWADDR,
  input  logic [IDW-1:0]  S_AXI_AWID,
  input  logic [7:0]      S_AXI_AWLEN,
  input  logic            S_AXI_AWVALID,
  output logic            S_AXI_AWREADY,
  input  logic [DW-1:0]   S_AXI_WDATA,
  input  logic [DW/8-1:0] S_AXI_WSTRB,
  input  logic            S_AXI_WLAST,
  input  logic            S_AXI_WVALID,
  output logic            S_AXI_WREADY,
  output logic [1:0]      S_AXI_BRESP,
  output logic [IDW-1:0]  S_AXI_BID,
  output logic            S_AXI_BVALID,
  input  logic            S_AXI_BREADY,
  input  logic [BA-1:0]   S_AXI_ARADDR,
  input  logic [IDW-1:0]  S_AXI_ARID,
  input  logic [7:0]      S_AXI_ARLEN,
  input  logic            S_AXI_ARVALID,
  output logic            S_AXI_ARREADY,
  output logic [DW-1:0]   S_AXI_RDATA,
  output logic [IDW-1:0]  S_AXI_RID,
  output logic [1:0]      S_AXI_RRESP,
  output logic            S_AXI_RLAST,
  output logic            S_AXI_RVALID,
  input  logic            S_AXI_RREADY
);
  localparam int BSH = $clog2(DW / 8);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_BURST} rstate_t;

  wstate_t         w_state, w_next;
  logic [AW-1:0]   w_addr;
  logic [7:0]      w_len, w_beat;
  logic [IDW-1:0]  w_id;
  logic            w_err;
  logic            aw_hs, w_hs, w_final;
  logic            we_q;
  logic [AW-1:0]   wa_q;
  logic [DW-1:0]   wd_q;
  logic [DW/8-1:0] ws_q;
  logic            unused;

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign w_final = (w_beat == w_len);
  assign unused  = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARVALID, S_AXI_RREADY};

  always_ff @(posedge clk) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_BRESP   = 2'b00;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        S_AXI_BRESP  = w_err ? 2'b10 : 2'b00;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end
  assign S_AXI_BID = w_id;

  // The burst length comes from AWLEN alone; WLAST only feeds the error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_addr <= '0;
      w_len  <= '0;
      w_id   <= '0;
      w_beat <= '0;
      w_err  <= 1'b0;
    end else if (aw_hs) begin
      w_addr <= S_AXI_AWADDR[BA-1:BSH];
      w_len  <= S_AXI_AWLEN;
      w_id   <= S_AXI_AWID;
      w_beat <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr + AW'(1);
      w_beat <= w_beat + 8'd1;
      if (S_AXI_WLAST != w_final) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      we_q              <= 1'b0;
      last_word_written <= 1'b0;
      wrap_count        <= '0;
    end else begin
      we_q              <= w_hs && (|S_AXI_WSTRB);
      last_word_written <= w_hs && (|S_AXI_WSTRB) && (w_addr == AW'(DD - 1));
      if (w_hs && (|S_AXI_WSTRB) && (w_addr == AW'(DD - 1))) wrap_count <= wrap_count + 32'd1;
    end
  end

  // Not reset, so a beat accepted just before reset still reaches the RAM.
  always_ff @(posedge clk) begin
    wa_q <= w_addr;
    wd_q <= S_AXI_WDATA;
    ws_q <= S_AXI_WSTRB;
  end

  sdp_ram_axi_bank #(.DW(DW), .DD(DD), .RAM_TYPE(RAM_TYPE)) u_local (
    .clk(clk), .we(we_q), .waddr(wa_q), .wdata(wd_q), .wstrb(ws_q),
    .raddr(addrb), .rdata(dob)
  );

  if (AXI_READ != 0) begin : g_read
    rstate_t        r_state, r_next;
    logic [AW-1:0]  r_addr;
    logic [7:0]     r_len;
    logic [IDW-1:0] r_id;
    logic [8:0]     r_cnt;
    logic           inflight, inflight_last, issue, pop;
    logic [DW-1:0]  ram_q;
    logic [DW-1:0]  fifo_dat [2];
    logic           fifo_last [2];
    logic           wp, rp;
    logic [1:0]     cnt;
    logic [2:0]     occ;

    sdp_ram_axi_bank #(.DW(DW), .DD(DD), .RAM_TYPE(RAM_TYPE)) u_axi (
      .clk(clk), .we(we_q), .waddr(wa_q), .wdata(wd_q), .wstrb(ws_q),
      .raddr(r_addr), .rdata(ram_q)
    );

    // Occupancy next cycle; a new read is issued only if its slot is guaranteed.
    assign pop   = (cnt != 2'd0) && S_AXI_RREADY;
    assign occ   = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (r_state == R_BURST) && (r_cnt <= {1'b0, r_len}) && (occ < 3'd2);

    always_ff @(posedge clk) begin
      if (!resetn) r_state <= R_IDLE;
      else         r_state <= r_next;
    end

    always_comb begin
      r_next = r_state;
      case (r_state)
        R_IDLE:  if (S_AXI_ARVALID) r_next = R_BURST;
        R_BURST: if (pop && fifo_last[rp]) r_next = R_IDLE;
        default: r_next = R_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_addr        <= '0;
        r_len         <= '0;
        r_id          <= '0;
        r_cnt         <= '0;
        inflight      <= 1'b0;
        inflight_last <= 1'b0;
        wp            <= 1'b0;
        rp            <= 1'b0;
        cnt           <= '0;
      end else begin
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          r_addr <= S_AXI_ARADDR[BA-1:BSH];
          r_len  <= S_AXI_ARLEN;
          r_id   <= S_AXI_ARID;
          r_cnt  <= '0;
        end else if (issue) begin
          r_addr <= r_addr + AW'(1);
          r_cnt  <= r_cnt + 9'd1;
        end
        inflight      <= issue;
        inflight_last <= (r_cnt == {1'b0, r_len});
        if (inflight) wp <= ~wp;
        if (pop)      rp <= ~rp;
        cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
      end
    end

    always_ff @(posedge clk) begin
      if (inflight) begin
        fifo_dat[wp]  <= ram_q;
        fifo_last[wp] <= inflight_last;
      end
    end

    assign S_AXI_ARREADY = (r_state == R_IDLE);
    assign S_AXI_RVALID  = (cnt != 2'd0);
    assign S_AXI_RDATA   = fifo_dat[rp];
    assign S_AXI_RLAST   = (cnt != 2'd0) && fifo_last[rp];
    assign S_AXI_RID     = r_id;
    assign S_AXI_RRESP   = 2'b00;
  end else begin : g_noread
    assign S_AXI_ARREADY = 1'b0;
    assign S_AXI_RVALID  = 1'b0;
    assign S_AXI_RDATA   = '0;
    assign S_AXI_RLAST   = 1'b0;
    assign S_AXI_RID     = '0;
    assign S_AXI_RRESP   = 2'b00;
  end
endmodule
